pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It sequences the IF/ID and ID/EX pipeline registers and the PC, covering three cases:
- load-use hazards: one-cycle bubble into EX;
- EX-stage redirects from a taken branch or jump: flush of IF/ID and ID/EX;
- multi-cycle EX operations: freeze of the front end with a start/done handshake and a timeout.
It also keeps a saturating stall-cycle counter for performance checks.

Parameters:
MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced release (>=2)
CNT_W, 16, width of stall_count

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a valid instruction
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_valid  input  1  EX stage holds a valid instruction
ex_memRead  input  1  EX instruction is a load
ex_rd  input  5  EX destination register
ex_redirect  input  1  EX resolved taken branch/jump this cycle
ex_mc_op  input  1  EX instruction needs the multi-cycle unit
mc_done  input  1  multi-cycle unit result valid (1-cycle pulse)
pc_write  output  1  PC may update
ifid_write  output  1  IF/ID may load
ifid_flush  output  1  IF/ID loads a bubble
idex_write  output  1  ID/EX may load
idex_flush  output  1  ID/EX loads a bubble (all control bits 0)
exmem_bubble  output  1  EX/MEM loads a bubble
mc_start  output  1  1-cycle start pulse to the multi-cycle unit
mc_error  output  1  sticky: a multi-cycle operation timed out
stall_count  output  CNT_W  cycles with pc_write=0, saturating

Behaviour:
- State: FSM {RUN, MC_WAIT}, wait counter wcnt (ceil(log2(MC_TIMEOUT+1)) bits), stall_count, mc_error.
- Control outputs are combinational from the state and current inputs. The default in RUN is pc_write=ifid_write=idex_write=1 and all other outputs 0.
- While rst=1: state=RUN, wcnt=0, stall_count=0, mc_error=0. Outputs are forced to pc_write=ifid_write=idex_write=0, ifid_flush=idex_flush=1, exmem_bubble=0, mc_start=0.
- Reset mid-operation: any MC_WAIT is abandoned immediately. After release the FSM is in RUN with counters at zero.
- RUN priority, highest first:
  1. ex_redirect & ex_valid → ifid_flush=1, idex_flush=1, pc_write=1 (loads the target). Load-use and MC start are suppressed. State stays RUN.
  2. ex_valid & ex_mc_op → mc_start=1 for this cycle only. pc_write=ifid_write=idex_write=0, exmem_bubble=1. Next state MC_WAIT, wcnt←1.
  3. Load-use: ex_valid & ex_memRead & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) → pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle. No state change.
- MC_WAIT:
  - pc_write=ifid_write=idex_write=0, exmem_bubble=1. ex_redirect, ex_mc_op and load-use are ignored.
  - mc_done=1 → release in the same cycle: idex_write=1, exmem_bubble=0, pc_write=ifid_write=1. Next state RUN, wcnt←0.
  - Else if wcnt==MC_TIMEOUT → mc_error←1 (sticky until rst). Release as for mc_done. Next state RUN.
  - Else wcnt←wcnt+1.
  - mc_done while in RUN is ignored.
- The mc_start cycle plus the MC_WAIT cycles form the stall window. Completion after N cycles (mc_done in the N-th MC_WAIT cycle) gives N stalled cycles (mc_start cycle plus N-1 held cycles); the done cycle itself advances.
- stall_count increments on every non-reset cycle with pc_write=0 and holds at 2^CNT_W-1.

Test Plan:
1. Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_use_rs2=1, all valid → one cycle of pc_write=0, ifid_write=0, idex_flush=1, then defaults; stall_count=1.
2. ex_rd=0 with a matching id_rs1=0 → no stall. Same hazard with id_use_rs1=0 → no stall.
3. ex_redirect=1 together with a load-use match and ex_mc_op=1 → ifid_flush=idex_flush=1, pc_write=1, mc_start=0; FSM stays RUN.
4. ex_mc_op=1, mc_done pulsed in the 5th MC_WAIT cycle → mc_start is a single pulse; 5 cycles with pc_write=0; the done cycle has idex_write=1, exmem_bubble=0; stall_count=5; mc_error=0.
5. MC_TIMEOUT=4, mc_done never asserted → release after the 4th MC_WAIT cycle; mc_error=1 and stays 1 through later ops until rst.
6. rst asserted asynchronously in the 2nd MC_WAIT cycle → outputs immediately take their reset values. After release: RUN, stall_count=0, mc_error=0; a late mc_done is ignored. With CNT_W=4, a long stall saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. It handles three cases:
//   - load-use hazards: a one-cycle bubble into EX;
//   - taken branch/jump redirects from EX: IF/ID and ID/EX are flushed;
//   - multi-cycle EX operations: the front end is frozen behind a start/done
//     handshake, with a timeout.
//   It also keeps a saturating count of cycles in which the PC was held.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   id_valid/id_rs1/id_rs2     ID stage instruction and its source registers
//   id_use_rs1/id_use_rs2      the ID instruction really reads rs1/rs2
//   ex_valid/ex_memRead/ex_rd  EX stage instruction, load flag, destination
//   ex_redirect                EX resolved a taken branch/jump
//   ex_mc_op                   EX instruction needs the multi-cycle unit
//   mc_done                    multi-cycle result valid (1-cycle pulse)
//   pc_write/ifid_write/idex_write   pipeline register enables
//   ifid_flush/idex_flush/exmem_bubble  bubble inserts
//   mc_start                   1-cycle start pulse to the multi-cycle unit
//   mc_error                   sticky multi-cycle timeout flag
//   stall_count                saturating count of cycles with pc_write=0
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal flow; redirect > mc start > load-use priority
// MC_WAIT | front end frozen, waiting for mc_done or the timeout
module pipeline_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_mc_op,
  input  logic             mc_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             mc_start,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WCNT_W = $clog2(MC_TIMEOUT + 1);

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_MC_WAIT = 1'b1;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MC_TIMEOUT);

  logic [0:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              err_set;
  logic              rs1_hit, rs2_hit, load_use;

  // x0 is never a real dependency, so ex_rd==0 never stalls.
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_memRead && (ex_rd != 5'd0) && id_valid &&
                    (rs1_hit || rs2_hit);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mc_start     = 1'b0;
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    err_set      = 1'b0;

    if (rst) begin
      // Reset holds the pipeline and fills it with bubbles.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nxt  = S_RUN;
      wcnt_nxt   = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (ex_redirect && ex_valid) begin
            // PC stays enabled so that it loads the branch target.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_valid && ex_mc_op) begin
            mc_start     = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            state_nxt    = S_MC_WAIT;
            wcnt_nxt     = WCNT_W'(1);
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        S_MC_WAIT: begin
          if (mc_done || (wcnt == WCNT_LAST)) begin
            // The release cycle advances the pipeline, with or without a result.
            state_nxt = S_RUN;
            wcnt_nxt  = '0;
            err_set   = !mc_done;
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            wcnt_nxt     = wcnt + WCNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_RUN;
          wcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      wcnt        <= '0;
      mc_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (err_set)
        mc_error <= 1'b1;
      if (!pc_write && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share the same inputs:
// instance 0 uses the default parameters, instance 1 uses MC_TIMEOUT=4 and
// CNT_W=4 (fast timeout and saturation). A behavioural model checks both
// instances on every falling edge. Directed sequences add literal
// expectations, and a randomized phase follows them.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic       ex_valid = 0, ex_memRead = 0, ex_redirect = 0, ex_mc_op = 0, mc_done = 0;

  logic [1:0]  pc_w, ifid_w, ifid_f, idex_w, idex_f, exb, mcs, mce;
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .pc_write(pc_w[0]),
    .ifid_write(ifid_w[0]), .ifid_flush(ifid_f[0]), .idex_write(idex_w[0]),
    .idex_flush(idex_f[0]), .exmem_bubble(exb[0]), .mc_start(mcs[0]),
    .mc_error(mce[0]), .stall_count(sc_a));

  pipeline_hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .ex_mc_op(ex_mc_op), .mc_done(mc_done), .pc_write(pc_w[1]),
    .ifid_write(ifid_w[1]), .ifid_flush(ifid_f[1]), .idex_write(idex_w[1]),
    .idex_flush(idex_f[1]), .exmem_bubble(exb[1]), .mc_start(mcs[1]),
    .mc_error(mce[1]), .stall_count(sc_b));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit pc; bit ifid; bit ifl; bit idex; bit idfl; bit exb; bit st;
  } exp_t;

  int lim  [2] = '{64, 4};
  int cmax [2] = '{65535, 15};
  bit busy [2] = '{0, 0};
  int waited [2] = '{0, 0};
  bit err  [2] = '{0, 0};
  int stalls [2] = '{0, 0};
  exp_t e_m;

  function automatic exp_t model_out(input bit is_busy, input int nwait, input int tmo);
    exp_t e;
    bit hit;
    if (rst) begin
      e = '{pc:0, ifid:0, ifl:1, idex:0, idfl:1, exb:0, st:0};
      return e;
    end
    e = '{pc:1, ifid:1, ifl:0, idex:1, idfl:0, exb:0, st:0};
    hit = ex_valid && ex_memRead && (ex_rd != 0) && id_valid &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (is_busy) begin
      if (!(mc_done || nwait >= tmo)) begin
        e.pc = 0; e.ifid = 0; e.idex = 0; e.exb = 1;
      end
    end else if (ex_redirect && ex_valid) begin
      e.ifl = 1; e.idfl = 1;
    end else if (ex_valid && ex_mc_op) begin
      e.st = 1; e.pc = 0; e.ifid = 0; e.idex = 0; e.exb = 1;
    end else if (hit) begin
      e.pc = 0; e.ifid = 0; e.idfl = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i] = 0; waited[i] = 0; err[i] = 0; stalls[i] = 0;
      end
      e_m = model_out(busy[i], waited[i], lim[i]);
      check($sformatf("m%0d.pc_write", i),     int'(pc_w[i]),   int'(e_m.pc));
      check($sformatf("m%0d.ifid_write", i),   int'(ifid_w[i]), int'(e_m.ifid));
      check($sformatf("m%0d.ifid_flush", i),   int'(ifid_f[i]), int'(e_m.ifl));
      check($sformatf("m%0d.idex_write", i),   int'(idex_w[i]), int'(e_m.idex));
      check($sformatf("m%0d.idex_flush", i),   int'(idex_f[i]), int'(e_m.idfl));
      check($sformatf("m%0d.exmem_bubble", i), int'(exb[i]),    int'(e_m.exb));
      check($sformatf("m%0d.mc_start", i),     int'(mcs[i]),    int'(e_m.st));
      check($sformatf("m%0d.mc_error", i),     int'(mce[i]),    int'(err[i]));
      check($sformatf("m%0d.stall_count", i),  (i == 0) ? int'(sc_a) : int'(sc_b), stalls[i]);
      if (!rst) begin
        if (!e_m.pc && stalls[i] < cmax[i]) stalls[i]++;
        if (!busy[i]) begin
          if (e_m.st) begin busy[i] = 1; waited[i] = 1; end
        end else if (mc_done || waited[i] >= lim[i]) begin
          busy[i] = 0;
          if (!mc_done) err[i] = 1;
        end else begin
          waited[i]++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_memRead = 0; ex_rd = 0; ex_redirect = 0; ex_mc_op = 0; mc_done = 0;
  endtask

  task automatic set_load_use();
    idle();
    ex_valid = 1; ex_memRead = 1; ex_rd = 5; id_valid = 1; id_rs2 = 5; id_use_rs2 = 1;
  endtask

  // rst edges land 3 time units after a rising edge, clear of both clock edges.
  task automatic do_reset();
    tick(); idle(); #2 rst = 1;
    tick(); #2 rst = 0;
  endtask

  initial begin
    // Reset state
    mid();
    check("rst.pc_write", int'(pc_w[0]), 0);
    check("rst.ifid_flush", int'(ifid_f[0]), 1);
    check("rst.stall_count", int'(sc_a), 0);
    tick(); #2 rst = 0;
    mid();
    check("run.default_pc", int'(pc_w[0]), 1);

    // Load-use: one-cycle stall
    tick(); set_load_use();
    mid();
    check("lu.pc_write", int'(pc_w[0]), 0);
    check("lu.ifid_write", int'(ifid_w[0]), 0);
    check("lu.idex_flush", int'(idex_f[0]), 1);
    tick(); idle();
    mid();
    check("lu.after_pc", int'(pc_w[0]), 1);
    check("lu.stall_count", int'(sc_a), 1);

    // ex_rd==0 and a hazard on an unused rs1 do not stall
    tick(); idle(); ex_valid = 1; ex_memRead = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0; id_use_rs1 = 1;
    mid(); check("lu.x0_nostall", int'(pc_w[0]), 1);
    tick(); idle(); ex_valid = 1; ex_memRead = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7; id_use_rs1 = 0;
    mid(); check("lu.unused_nostall", int'(pc_w[0]), 1);

    // Redirect wins over load-use and mc start
    tick(); idle(); ex_valid = 1; ex_redirect = 1; ex_memRead = 1; ex_rd = 3;
    id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; ex_mc_op = 1;
    mid();
    check("redir.ifid_flush", int'(ifid_f[0]), 1);
    check("redir.idex_flush", int'(idex_f[0]), 1);
    check("redir.pc_write", int'(pc_w[0]), 1);
    check("redir.mc_start", int'(mcs[0]), 0);
    tick(); idle();
    mid();
    check("redir.still_run", int'(exb[0]), 0);
    check("redir.stall_count", int'(sc_a), 1);

    // Multi-cycle op, done in the 5th MC_WAIT cycle (instance 1 times out after 4)
    do_reset();
    tick(); idle(); ex_valid = 1; ex_mc_op = 1;
    mid();
    check("mc.start", int'(mcs[0]), 1);
    check("mc.start_pc", int'(pc_w[0]), 0);
    for (int k = 1; k <= 5; k++) begin
      tick(); idle(); mc_done = (k == 5);
      mid();
      check($sformatf("mc.w%0d.start", k), int'(mcs[0]), 0);
      check($sformatf("mc.w%0d.pc", k), int'(pc_w[0]), (k == 5) ? 1 : 0);
      check($sformatf("mc.w%0d.exb", k), int'(exb[0]), (k == 5) ? 0 : 1);
      check($sformatf("mc.w%0d.idex_write", k), int'(idex_w[0]), (k == 5) ? 1 : 0);
    end
    check("tmo.b_error", int'(mce[1]), 1);
    tick(); idle();
    mid();
    check("mc.stall_count", int'(sc_a), 5);
    check("mc.error", int'(mce[0]), 0);
    check("tmo.b_stall_count", int'(sc_b), 4);

    // mc_error stays set through a later op that completes normally
    tick(); idle(); ex_valid = 1; ex_mc_op = 1;
    tick(); idle(); mc_done = 1;
    tick(); idle();
    mid();
    check("tmo.b_sticky", int'(mce[1]), 1);
    check("mc2.error", int'(mce[0]), 0);

    // Async reset in the 2nd MC_WAIT cycle
    tick(); idle(); ex_valid = 1; ex_mc_op = 1;
    tick(); idle();
    tick(); idle();
    #2 rst = 1;
    #1;
    check("arst.pc_write", int'(pc_w[0]), 0);
    check("arst.ifid_flush", int'(ifid_f[0]), 1);
    check("arst.exmem_bubble", int'(exb[0]), 0);
    check("arst.b_error", int'(mce[1]), 0);
    tick(); #2 rst = 0;
    mid();
    check("arst.after_pc", int'(pc_w[0]), 1);
    check("arst.stall_count", int'(sc_a), 0);
    tick(); idle(); mc_done = 1;
    mid();
    check("arst.late_done_pc", int'(pc_w[0]), 1);
    check("arst.late_done_exb", int'(exb[0]), 0);

    // Saturation: 20 stalled cycles
    for (int k = 0; k < 20; k++) begin
      tick(); set_load_use();
    end
    tick(); idle();
    mid();
    check("sat.a_count", int'(sc_a), 20);
    check("sat.b_count", int'(sc_b), 15);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      tick();
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_valid    = ($urandom_range(0, 4) != 0);
      ex_memRead  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_mc_op    = ($urandom_range(0, 7) == 0);
      mc_done     = ($urandom_range(0, 5) == 0);
      if (rst) begin
        #2 rst = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
      end
    end
    tick(); idle(); rst = 0;
    mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
